// File: rtl/nn_result_collector.sv
// Scoreboard stage: counts correct classifications against a label ROM over a run,
// then computes floor(100*correct/NUM_TESTS) with a restoring shift-subtract divider.
module nn_result_collector #(
    parameter int NUM_TESTS = 750,
    parameter int IDX_W     = 10,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    input  logic [DATA_W-1:0] label_data,
    output logic [IDX_W-1:0]  label_idx,
    output logic [IDX_W-1:0]  correct_cnt,
    output logic [IDX_W-1:0]  total_cnt,
    output logic [6:0]        accuracy,
    output logic              mismatch,
    output logic              busy,
    output logic              result_ready
);
    localparam int               NUM_W       = 17;
    localparam logic [IDX_W-1:0] ONE_C       = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_M1_C   = IDX_W'(NUM_TESTS - 1);
    localparam logic [IDX_W:0]   DIVISOR_C   = (IDX_W + 1)'(NUM_TESTS);
    localparam logic [4:0]       ITER_LAST_C = 5'd16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DIVIDE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] correct_q, correct_d;
    logic [IDX_W-1:0] total_q, total_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [IDX_W-1:0] rem_q, rem_d;
    logic [5:0]       quot_q, quot_d;
    logic [4:0]       iter_q, iter_d;
    logic [6:0]       acc_q, acc_d;
    logic             mismatch_q, mismatch_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic             match_s;
    logic [IDX_W-1:0] correct_inc_s;
    logic [NUM_W-1:0] c_ext_s;
    logic [IDX_W:0]   rem_shift_s;
    logic             rem_ge_s;

    assign match_s       = (res_data == label_data);
    assign correct_inc_s = correct_q + {{(IDX_W - 1){1'b0}}, match_s};
    assign c_ext_s       = NUM_W'(correct_inc_s);
    assign rem_shift_s   = {rem_q, num_q[NUM_W-1]};
    assign rem_ge_s      = (rem_shift_s >= DIVISOR_C);

    // Next-state, counter and divider datapath; start overrides everything.
    always_comb begin
        state_d    = state_q;
        correct_d  = correct_q;
        total_d    = total_q;
        num_d      = num_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        iter_d     = iter_q;
        acc_d      = acc_q;
        mismatch_d = 1'b0;
        if (start) begin
            state_d   = COLLECT;
            correct_d = '0;
            total_d   = '0;
            num_d     = '0;
            rem_d     = '0;
            quot_d    = '0;
            iter_d    = 5'd0;
            acc_d     = 7'd0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (res_valid) begin
                        total_d    = total_q + ONE_C;
                        correct_d  = correct_inc_s;
                        mismatch_d = !match_s;
                        if (total_q == LAST_M1_C) begin
                            // c*100 = c*64 + c*32 + c*4
                            num_d   = (c_ext_s << 6) + (c_ext_s << 5) + (c_ext_s << 2);
                            rem_d   = '0;
                            quot_d  = '0;
                            iter_d  = 5'd0;
                            state_d = DIVIDE;
                        end else begin
                            state_d = COLLECT;
                        end
                    end else begin
                        state_d = COLLECT;
                    end
                end
                DIVIDE: begin
                    num_d  = {num_q[NUM_W-2:0], 1'b0};
                    rem_d  = rem_ge_s ? IDX_W'(rem_shift_s - DIVISOR_C) : rem_shift_s[IDX_W-1:0];
                    quot_d = {quot_q[4:0], rem_ge_s};
                    iter_d = iter_q + 5'd1;
                    // Quotient never exceeds 100, so the last 7 bits are the whole result.
                    if (iter_q == ITER_LAST_C) begin
                        acc_d   = {quot_q, rem_ge_s};
                        state_d = DONE;
                    end else begin
                        state_d = DIVIDE;
                    end
                end
                IDLE:    state_d = IDLE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
        busy_d  = (state_d == COLLECT) || (state_d == DIVIDE);
        ready_d = (state_d == DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            correct_q  <= '0;
            total_q    <= '0;
            num_q      <= '0;
            rem_q      <= '0;
            quot_q     <= 6'd0;
            iter_q     <= 5'd0;
            acc_q      <= 7'd0;
            mismatch_q <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            correct_q  <= correct_d;
            total_q    <= total_d;
            num_q      <= num_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            iter_q     <= iter_d;
            acc_q      <= acc_d;
            mismatch_q <= mismatch_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign label_idx    = total_q;
    assign total_cnt    = total_q;
    assign correct_cnt  = correct_q;
    assign accuracy     = acc_q;
    assign mismatch     = mismatch_q;
    assign busy         = busy_q;
    assign result_ready = ready_q;
endmodule

// File: tb/tb_nn_result_collector.sv
// Scoreboard bench for nn_result_collector: NUM_TESTS=750 main instance plus a
// NUM_TESTS=3 instance for the small-run rounding case.
module tb_nn_result_collector;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, res_valid = 1'b0;
    logic [7:0] res_data = 8'd0, label_data;
    logic [9:0] label_idx, correct_cnt, total_cnt;
    logic [6:0] accuracy;
    logic       mismatch, busy, result_ready;

    logic       start3 = 1'b0, res_valid3 = 1'b0;
    logic [7:0] res_data3 = 8'd0, label_data3;
    logic [9:0] label_idx3, correct_cnt3, total_cnt3;
    logic [6:0] accuracy3;
    logic       mismatch3, busy3, result_ready3;

    int   n_checks = 0, n_errors = 0;
    int   exp_total = 0, exp_correct = 0, mm_cnt = 0;
    logic mm_q[$];
    int   acc_q[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [9:0] idx);
        return 8'(idx * 10'd37 + 10'd11);
    endfunction

    assign label_data  = rom(label_idx);
    assign label_data3 = rom(label_idx3);

    nn_result_collector #(.NUM_TESTS(750), .IDX_W(10), .DATA_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res_data(res_data),
        .label_data(label_data), .label_idx(label_idx), .correct_cnt(correct_cnt),
        .total_cnt(total_cnt), .accuracy(accuracy), .mismatch(mismatch), .busy(busy),
        .result_ready(result_ready));

    nn_result_collector #(.NUM_TESTS(3), .IDX_W(10), .DATA_W(8)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .res_valid(res_valid3), .res_data(res_data3),
        .label_data(label_data3), .label_idx(label_idx3), .correct_cnt(correct_cnt3),
        .total_cnt(total_cnt3), .accuracy(accuracy3), .mismatch(mismatch3), .busy(busy3),
        .result_ready(result_ready3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_ok(input int mode, input int i);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (i != 300);
            3:       return (i % 7) != 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_total"}, total_cnt, 0);
        chk({tag, "_correct"}, correct_cnt, 0);
        chk({tag, "_label_idx"}, label_idx, 0);
        chk({tag, "_accuracy"}, accuracy, 0);
        chk({tag, "_mismatch"}, mismatch, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, result_ready, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_total = 0;
        exp_correct = 0;
        mm_cnt = 0;
        chk("start_busy", busy, 1);
        chk("start_total", total_cnt, 0);
        chk("start_correct", correct_cnt, 0);
        chk("start_accuracy", accuracy, 0);
        chk("start_ready", result_ready, 0);
    endtask

    task automatic send(input logic ok);
        logic exp_mm;
        res_valid = 1'b1;
        res_data  = ok ? rom(10'(exp_total)) : ~rom(10'(exp_total));
        mm_q.push_back(!ok);
        tick();
        exp_mm = mm_q.pop_front();
        chk("mismatch", mismatch, exp_mm);
        if (mismatch) mm_cnt++;
        exp_total++;
        if (ok) exp_correct++;
        chk("total_cnt", total_cnt, exp_total);
        chk("label_idx", label_idx, exp_total);
    endtask

    task automatic run(input int mode);
        pulse_start();
        for (int i = 0; i < 750; i++) send(is_ok(mode, i));
        res_valid = 1'b0;
        acc_q.push_back((exp_correct * 100) / 750);
        chk("div_busy", busy, 1);
        chk("div_ready", result_ready, 0);
    endtask

    task automatic finish_run(input int elapsed);
        int lat;
        int exp_acc;
        lat = elapsed;
        while (result_ready !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk("latency", lat, 17);
        exp_acc = acc_q.pop_front();
        chk("accuracy", accuracy, exp_acc);
        chk("correct_cnt", correct_cnt, exp_correct);
        chk("done_busy", busy, 0);
        chk("mismatch_count", mm_cnt, exp_total - exp_correct);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat3;
        #3;
        chk_reset("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Strobe in IDLE is ignored
        res_valid = 1'b1;
        res_data  = rom(10'd0);
        tick();
        res_valid = 1'b0;
        chk("idle_total", total_cnt, 0);
        chk("idle_busy", busy, 0);

        run(0);
        finish_run(0);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("done_total", total_cnt, 750);
        chk("done_ready", result_ready, 1);
        chk("done_accuracy", accuracy, 100);

        run(1);
        finish_run(0);

        // Strobes during DIVIDE must leave counters frozen
        run(2);
        res_valid = 1'b1;
        tick();
        tick();
        res_valid = 1'b0;
        chk("divide_total", total_cnt, 750);
        chk("divide_correct", correct_cnt, 749);
        finish_run(2);

        // start coincident with a result discards it
        pulse_start();
        for (int i = 0; i < 10; i++) send(1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        res_valid = 1'b0;
        chk("restart_total", total_cnt, 0);
        chk("restart_correct", correct_cnt, 0);
        chk("restart_busy", busy, 1);
        chk("restart_mismatch", mismatch, 0);

        // start during DIVIDE aborts the division
        run(0);
        tick();
        tick();
        tick();
        pulse_start();
        acc_q.delete();

        // Reset mid-divide, then a clean full run
        run(3);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk_reset("middiv_reset");
        acc_q.delete();
        tick();
        rst = 1'b1;
        tick();
        run(3);
        finish_run(0);

        // NUM_TESTS=3: two correct, one wrong -> 66
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("n3_busy", busy3, 1);
        for (int i = 0; i < 3; i++) begin
            res_valid3 = 1'b1;
            res_data3  = (i < 2) ? rom(10'(i)) : ~rom(10'(i));
            tick();
        end
        res_valid3 = 1'b0;
        acc_q.push_back((2 * 100) / 3);
        lat3 = 0;
        while (result_ready3 !== 1'b1 && lat3 < 100) begin
            tick();
            lat3++;
        end
        chk("n3_latency", lat3, 17);
        chk("n3_accuracy", accuracy3, acc_q.pop_front());
        chk("n3_correct", correct_cnt3, 2);
        chk("n3_total", total_cnt3, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
